// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a two-state sequencer that drives J/K of a downstream flip-flop.
// Optional sticky overflow output enabled by defining JK_CMD_SEQUENCER_OVF_EN.
module jk_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   input  logic [1:0]               cmd_op,
   input  logic [3:0]               cmd_count,
   output logic                     cmd_ready,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   level
`ifdef JK_CMD_SEQUENCER_OVF_EN
   ,
   output logic                     ovf
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_t;

   state_t         state_r;
   logic [5:0]     mem_r [DEPTH];
   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [LW-1:0]  level_r;
   logic           ready_r;
   logic           j_r;
   logic           k_r;
   logic           busy_r;
   logic           done_r;
   logic [3:0]     rem_r;
   logic           push_s;
   logic           pop_s;
   logic           last_s;
   logic [5:0]     head_s;
   logic [LW-1:0]  level_nxt_s;

   // A zero count still applies the operation once, so it leaves zero further cycles.
   function automatic logic [3:0] reps_left(input logic [3:0] c);
      if (c == 4'd0) begin
         reps_left = 4'd0;
      end else begin
         reps_left = c - 4'd1;
      end
   endfunction

   // Handshake, pop decision and next occupancy.
   always_comb begin
      push_s      = cmd_valid & ready_r;
      head_s      = mem_r[rd_ptr_r];
      level_nxt_s = level_r;
      if (state_r == APPLY) begin
         last_s = (rem_r == 4'd0);
      end else begin
         last_s = 1'b1;
      end
      pop_s = last_s & (level_r != {LW{1'b0}});
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LW'(1'b1);
         2'b01:   level_nxt_s = level_r - LW'(1'b1);
         default: level_nxt_s = level_r;
      endcase
   end

   // Command storage; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {cmd_op, cmd_count};
      end
   end

   // Pointers, occupancy and the registered ready (not-full) flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
         ready_r  <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         level_r <= level_nxt_s;
         ready_r <= (level_nxt_s != LW'(DEPTH));
      end
   end

   // Sequencer FSM with registered J/K, busy and done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         j_r     <= 1'b0;
         k_r     <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rem_r   <= 4'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  {j_r, k_r} <= head_s[5:4];
                  rem_r      <= reps_left(head_s[3:0]);
                  state_r    <= APPLY;
                  busy_r     <= 1'b1;
               end else begin
                  j_r <= 1'b0;
                  k_r <= 1'b0;
               end
            end
            APPLY: begin
               if (rem_r != 4'd0) begin
                  rem_r <= rem_r - 4'd1;
               end else if (pop_s) begin
                  {j_r, k_r} <= head_s[5:4];
                  rem_r      <= reps_left(head_s[3:0]);
               end else begin
                  j_r     <= 1'b0;
                  k_r     <= 1'b0;
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               j_r     <= 1'b0;
               k_r     <= 1'b0;
               busy_r  <= 1'b0;
               rem_r   <= 4'd0;
            end
         endcase
      end
   end

   assign cmd_ready = ready_r;
   assign j         = j_r;
   assign k         = k_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign level     = level_r;

`ifdef JK_CMD_SEQUENCER_OVF_EN
   logic ovf_r;

   // Sticky flag for any command offered while the FIFO is full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (cmd_valid & ~ready_r) begin
         ovf_r <= 1'b1;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: directed scenarios followed by random traffic,
// all compared against a queue-based command model.
module tb_jk_cmd_sequencer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [3:0] cmd_count;
   logic       cmd_ready;
   logic       j;
   logic       k;
   logic       busy;
   logic       done;
   logic [$clog2(DEPTH):0] level;
`ifdef JK_CMD_SEQUENCER_OVF_EN
   logic       ovf;
`endif

   jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_count (cmd_count),
      .cmd_ready (cmd_ready),
      .j         (j),
      .k         (k),
      .busy      (busy),
      .done      (done),
      .level     (level)
`ifdef JK_CMD_SEQUENCER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model: pending commands, the command being applied and its cycles left.
   logic [5:0] q[$];
   bit         m_active;
   int         m_left;
   logic [1:0] m_jk;
   bit         m_done;
   bit         m_ovf;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".j"},     8'(j),         8'(m_jk[1]));
      chk({tag, ".k"},     8'(k),         8'(m_jk[0]));
      chk({tag, ".busy"},  8'(busy),      8'(m_active));
      chk({tag, ".done"},  8'(done),      8'(m_done));
      chk({tag, ".level"}, 8'(level),     8'(q.size()));
      chk({tag, ".ready"}, 8'(cmd_ready), 8'(q.size() < DEPTH));
`ifdef JK_CMD_SEQUENCER_OVF_EN
      chk({tag, ".ovf"},   8'(ovf),       8'(m_ovf));
`endif
   endtask

   task automatic model_reset();
      q.delete();
      m_active = 1'b0;
      m_left   = 0;
      m_jk     = 2'b00;
      m_done   = 1'b0;
      m_ovf    = 1'b0;
   endtask

   // One clock cycle: offer (v, op, c), advance the model by the command rules, check.
   task automatic step(input string tag, input bit v, input logic [1:0] op, input logic [3:0] c);
      bit         acc;
      logic [5:0] cmd;
      cmd_valid = v;
      cmd_op    = op;
      cmd_count = c;
      @(posedge clk);
      acc    = v && (q.size() < DEPTH);
      if (v && !acc) m_ovf = 1'b1;
      m_done = 1'b0;
      if (m_active && m_left > 1) begin
         m_left--;
      end else if (q.size() > 0) begin
         cmd      = q.pop_front();
         m_jk     = cmd[5:4];
         m_left   = (cmd[3:0] == 4'd0) ? 1 : int'(cmd[3:0]);
         m_active = 1'b1;
      end else begin
         m_done   = m_active;
         m_active = 1'b0;
         m_jk     = 2'b00;
      end
      if (acc) q.push_back({op, c});
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 2'b00, 4'd0);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_count = 4'd0;
      model_reset();
      #3;
      check_all("por");
      @(negedge clk);
      rst = 1'b0;
      idle("idle0", 2);

      // Single set command, three cycles
      step("single", 1'b1, 2'b10, 4'd3);
      idle("single", 6);

      // Back-to-back reset then toggle
      step("b2b", 1'b1, 2'b01, 4'd1);
      step("b2b", 1'b1, 2'b11, 4'd2);
      idle("b2b", 5);

      // Zero count behaves as one
      step("zero", 1'b1, 2'b11, 4'd0);
      idle("zero", 3);

      // Fill beyond capacity with long commands
      for (int i = 0; i < 7; i++) step("full", 1'b1, 2'(i), 4'd15);
      idle("full", 3);
      async_reset("full_rst");
      idle("after_full", 3);

      // Reset while busy with two queued commands
      step("midop", 1'b1, 2'b10, 4'd15);
      step("midop", 1'b1, 2'b11, 4'd15);
      step("midop", 1'b1, 2'b01, 4'd15);
      chk("midop.pre_busy",  8'(busy),  8'd1);
      chk("midop.pre_level", 8'(level), 8'd2);
      async_reset("midop_rst");
      idle("after_midop", 20);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), c);
      end
      idle("drain", 80);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
